// File: rtl/pc_sequencer_if.sv
// Bundle of control inputs and status outputs for the PC sequencer.
// master : driven by the fetch/decode side (control in, PC/status out to it)
// slave  : the sequencer itself
//   stall_i, branch_taken_i, branch_offset_i, jump_i, call_i, return_i,
//   jump_target_i              -> next-PC selection controls
//   pc_o, pc_plus_o            -> current PC and PC + STEP
//   ras_empty_o, ras_full_o,
//   ras_error_o                -> return-address-stack status
interface pc_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic             stall_i;
   logic             branch_taken_i;
   logic [WIDTH-1:0] branch_offset_i;
   logic             jump_i;
   logic             call_i;
   logic             return_i;
   logic [WIDTH-1:0] jump_target_i;
   logic [WIDTH-1:0] pc_o;
   logic [WIDTH-1:0] pc_plus_o;
   logic             ras_empty_o;
   logic             ras_full_o;
   logic             ras_error_o;

   modport master (
      output stall_i, branch_taken_i, branch_offset_i, jump_i, call_i,
             return_i, jump_target_i,
      input  pc_o, pc_plus_o, ras_empty_o, ras_full_o, ras_error_o
   );

   modport slave (
      input  stall_i, branch_taken_i, branch_offset_i, jump_i, call_i,
             return_i, jump_target_i,
      output pc_o, pc_plus_o, ras_empty_o, ras_full_o, ras_error_o
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a circular return-address stack (RAS).
// Ports:
//   clk  - rising-edge clock for all state
//   rst  - asynchronous active-high reset
//   bus  - pc_sequencer_if.slave (controls in, PC and RAS status out)
// Next-PC priority when not stalled: Return, Call/Jump, BranchTaken, PC+STEP.
module pc_sequencer #(
   parameter int unsigned      WIDTH        = 32,
   parameter int unsigned      STEP         = 1,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned      RAS_DEPTH    = 4
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);

   localparam int unsigned      PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH + 1);
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pc_plus;
   logic [WIDTH-1:0] branch_tgt;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] wr_ptr_inc;
   logic [PTR_W-1:0] top_idx;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             push_en;
   logic [WIDTH-1:0] ras_q [RAS_DEPTH];

   assign pc_plus    = pc_q + STEP_W;
   // Unsigned multiply gives the same low WIDTH bits as the signed product.
   assign branch_tgt = pc_plus + (bus.branch_offset_i * STEP_W);

   // wr_ptr_q is the slot the next push lands in; the top entry sits one below.
   // When full, wr_ptr_q also points at the oldest entry, so an overflow push
   // overwrites it without any extra bookkeeping.
   assign wr_ptr_inc = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
   assign top_idx    = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - 1'b1;

   always_comb begin
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      push_en  = 1'b0;
      if (!bus.stall_i) begin
         if (bus.return_i) begin
            if (cnt_q != '0) begin
               pc_d     = ras_q[top_idx];
               wr_ptr_d = top_idx;
               cnt_d    = cnt_q - 1'b1;
            end else begin
               pc_d  = pc_plus;
               err_d = 1'b1;
            end
         end else if (bus.call_i) begin
            pc_d     = bus.jump_target_i;
            push_en  = 1'b1;
            wr_ptr_d = wr_ptr_inc;
            if (cnt_q == CNT_FULL) begin
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else if (bus.jump_i) begin
            pc_d = bus.jump_target_i;
         end else if (bus.branch_taken_i) begin
            pc_d = branch_tgt;
         end else begin
            pc_d = pc_plus;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_VECTOR;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // Entry storage is not reset; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_en) begin
         ras_q[wr_ptr_q] <= pc_plus;
      end
   end

   assign bus.pc_o        = pc_q;
   assign bus.pc_plus_o   = pc_plus;
   assign bus.ras_empty_o = (cnt_q == '0);
   assign bus.ras_full_o  = (cnt_q == CNT_FULL);
   assign bus.ras_error_o = err_q;

endmodule
